// File: rtl/sensor_ascii_formatter_if.sv
// Handshake bundle between the sensor sampler, the ASCII row formatter and the
// LCD row writer. The sampler side (master) offers samples; the formatter
// side (slave) accepts them and publishes the formatted row.
interface sensor_ascii_formatter_if #(
    parameter int DATA_W    = 8,
    parameter int ROW_CHARS = 16
);
    logic                   in_valid;
    logic [DATA_W-1:0]      in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [ROW_CHARS*8-1:0] ascii_row;
    logic                   overflow;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  ascii_row,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output ascii_row,
        output overflow
    );
endinterface

// File: rtl/sensor_ascii_formatter.sv
// Sequential binary-to-ASCII row formatter for the LCD text path.
// A sample is captured on the valid/ready handshake, converted to decimal by a
// shift-add-3 (double-dabble) engine one bit per clock, and published as a
// registered row: PREFIX, NUM_DIGITS digits, then space padding.
// Optional feature macro: LEADING_ZERO_BLANK_EN renders leading zero digits as
// spaces (the least-significant digit always shows; overflow rows are unaffected).
// The interface instance must be built with the same DATA_W and ROW_CHARS.
module sensor_ascii_formatter #(
    parameter int                      DATA_W       = 8,
    parameter int                      NUM_DIGITS   = 3,
    parameter int                      ROW_CHARS    = 16,
    parameter int                      PREFIX_CHARS = 6,
    parameter logic [PREFIX_CHARS*8-1:0] PREFIX     = "SENS: "
) (
    input  logic                      clk,
    input  logic                      rst,
    sensor_ascii_formatter_if.slave   bus
);

    // Number of decimal digits needed to hold the largest DATA_W-bit value.
    function automatic int dec_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    localparam int          FULL_DIGITS = dec_digits(DATA_W);
    localparam int          BCD_DIGITS  = (FULL_DIGITS > NUM_DIGITS) ? FULL_DIGITS : NUM_DIGITS;
    localparam int          BCD_W       = 4 * BCD_DIGITS;
    localparam int          CNT_W       = $clog2(DATA_W + 1);
    localparam logic [63:0] MAX_SHOWN   = 64'(10**NUM_DIGITS - 1);

    // Reject configurations that cannot produce a sensible row.
    if (PREFIX_CHARS + NUM_DIGITS > ROW_CHARS) begin : g_row_too_short
        $error("sensor_ascii_formatter: PREFIX_CHARS + NUM_DIGITS exceeds ROW_CHARS");
    end
    if (DATA_W < 1 || DATA_W > 20) begin : g_bad_data_w
        $error("sensor_ascii_formatter: DATA_W must be 1..20");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 7) begin : g_bad_num_digits
        $error("sensor_ascii_formatter: NUM_DIGITS must be 1..7");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   load;
    logic                   shift;
    logic                   emit;

    logic [DATA_W-1:0]      bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [BCD_W-1:0]       bcd_adj;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;

    logic [ROW_CHARS*8-1:0] row_q;
    logic [ROW_CHARS*8-1:0] row_d;
    logic                   overflow_q;
    logic                   out_valid_q;

    // State register; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing: accept in IDLE, DATA_W shift steps in CONV, one publish step in FMT.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                shift = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FMT;
                end
            end
            FMT: begin
                emit    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: capture the sample, then shift {bcd,bin} left once per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (load) begin
            bin_q <= bus.in_data;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
            ovf_q <= (64'(bus.in_data) > MAX_SHOWN);
        end else if (shift) begin
            bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Row assembly: prefix, low NUM_DIGITS BCD nibbles as ASCII, spaces everywhere else.
    always_comb begin
        logic [3:0] nib;
        logic [7:0] ch;
`ifdef LEADING_ZERO_BLANK_EN
        logic       leading;
        leading = 1'b1;
`endif
        row_d = {ROW_CHARS{8'h20}};
        nib   = 4'd0;
        ch    = 8'h20;
        for (int c = 0; c < PREFIX_CHARS; c++) begin
            row_d[(ROW_CHARS-1-c)*8 +: 8] = PREFIX[(PREFIX_CHARS-1-c)*8 +: 8];
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = bcd_q[4*(NUM_DIGITS-1-i) +: 4];
            ch  = {4'h3, nib};
`ifdef LEADING_ZERO_BLANK_EN
            if (leading && nib == 4'd0 && i != NUM_DIGITS - 1) begin
                ch = 8'h20;
            end else begin
                leading = 1'b0;
            end
`endif
            if (ovf_q) begin
                ch = 8'h39;
            end
            row_d[(ROW_CHARS-1-PREFIX_CHARS-i)*8 +: 8] = ch;
        end
    end

    // Output registers: row and overflow hold between conversions; out_valid pulses once per row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q       <= {ROW_CHARS{8'h20}};
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= emit;
            if (emit) begin
                row_q      <= row_d;
                overflow_q <= ovf_q;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.ascii_row = row_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_sensor_ascii_formatter.sv
// Directed bench for sensor_ascii_formatter: an 8-bit/3-digit instance for the
// main paths and a 10-bit/3-digit instance for overflow behaviour.
module tb_sensor_ascii_formatter;

    localparam logic [127:0] ROW_SPACES = "                ";

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    sensor_ascii_formatter_if #(.DATA_W(8),  .ROW_CHARS(16)) bus8 ();
    sensor_ascii_formatter_if #(.DATA_W(10), .ROW_CHARS(16)) bus10 ();

    sensor_ascii_formatter #(
        .DATA_W(8), .NUM_DIGITS(3), .ROW_CHARS(16), .PREFIX_CHARS(6), .PREFIX("SENS: ")
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    sensor_ascii_formatter #(
        .DATA_W(10), .NUM_DIGITS(3), .ROW_CHARS(16), .PREFIX_CHARS(6), .PREFIX("SENS: ")
    ) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report any difference.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    // Drive the sample inputs of the selected instance (0 = 8-bit, 1 = 10-bit).
    task automatic driveIn(input int sel, input logic valid, input logic [15:0] data);
        if (sel == 0) begin
            bus8.in_valid = valid;
            bus8.in_data  = data[7:0];
        end else begin
            bus10.in_valid = valid;
            bus10.in_data  = data[9:0];
        end
    endtask

    // Offer one sample, then watch 16 cycles: optional stray in_valid at cycle
    // injAt, optional one-cycle reset at cycle rstAt; report pulses and first row.
    task automatic applyStimulus(
        input  int            sel,
        input  logic [15:0]   value,
        input  int            injAt,
        input  logic [15:0]   injVal,
        input  int            rstAt,
        output int            pulses,
        output int            latency,
        output logic [127:0]  row,
        output logic          ovf,
        output logic          readyAtPulse,
        output logic [127:0]  rstRow,
        output logic          rstReady
    );
        logic rdy;
        logic ov;
        pulses       = 0;
        latency      = -1;
        row          = '0;
        ovf          = 1'b0;
        readyAtPulse = 1'b0;
        rstRow       = '0;
        rstReady     = 1'b0;
        rdy          = 1'b0;
        for (int w = 0; w < 20 && !rdy; w++) begin
            @(negedge clk);
            rdy = (sel == 0) ? bus8.in_ready : bus10.in_ready;
        end
        checkOutput("accept_ready", 128'(rdy), 128'(1));
        driveIn(sel, 1'b1, value);
        @(posedge clk);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            ov = (sel == 0) ? bus8.out_valid : bus10.out_valid;
            if (ov) begin
                pulses++;
                if (pulses == 1) begin
                    latency      = n;
                    row          = (sel == 0) ? bus8.ascii_row : bus10.ascii_row;
                    ovf          = (sel == 0) ? bus8.overflow  : bus10.overflow;
                    readyAtPulse = (sel == 0) ? bus8.in_ready  : bus10.in_ready;
                end
            end
            if (rstAt > 0 && n == rstAt + 1) begin
                rstRow   = (sel == 0) ? bus8.ascii_row : bus10.ascii_row;
                rstReady = (sel == 0) ? bus8.in_ready  : bus10.in_ready;
                rst      = 1'b0;
            end
            if (n == 1) driveIn(sel, 1'b0, 16'd0);
            if (injAt > 0 && n == injAt) driveIn(sel, 1'b1, injVal);
            if (injAt > 0 && n == injAt + 1) driveIn(sel, 1'b0, 16'd0);
            if (rstAt > 0 && n == rstAt) rst = 1'b1;
        end
    endtask

    // Normal conversion on the 8-bit instance with full checks.
    task automatic runSample8(input string tag, input logic [15:0] value, input logic [127:0] expRow);
        int           pulses;
        int           latency;
        logic [127:0] row;
        logic         ovf;
        logic         rdyP;
        logic [127:0] rr;
        logic         rrdy;
        applyStimulus(0, value, 0, 16'd0, 0, pulses, latency, row, ovf, rdyP, rr, rrdy);
        checkOutput({tag, "_row"},     row,             expRow);
        checkOutput({tag, "_latency"}, 128'(latency),   128'(10));
        checkOutput({tag, "_overflow"},128'(ovf),       128'(0));
        checkOutput({tag, "_pulses"},  128'(pulses),    128'(1));
        checkOutput({tag, "_ready"},   128'(rdyP),      128'(1));
    endtask

    // Conversion on the 10-bit instance checking row and overflow flag.
    task automatic runSample10(input string tag, input logic [15:0] value,
                               input logic [127:0] expRow, input logic expOvf);
        int           pulses;
        int           latency;
        logic [127:0] row;
        logic         ovf;
        logic         rdyP;
        logic [127:0] rr;
        logic         rrdy;
        applyStimulus(1, value, 0, 16'd0, 0, pulses, latency, row, ovf, rdyP, rr, rrdy);
        checkOutput({tag, "_row"},      row,           expRow);
        checkOutput({tag, "_overflow"}, 128'(ovf),     128'(expOvf));
        checkOutput({tag, "_latency"},  128'(latency), 128'(12));
    endtask

    // Directed sequence.
    initial begin
        int           pulses;
        int           latency;
        logic [127:0] row;
        logic         ovf;
        logic         rdyP;
        logic [127:0] rr;
        logic         rrdy;
        logic [127:0] exp7;
        logic [127:0] exp0;
        logic [127:0] exp40;

        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        driveIn(0, 1'b0, 16'd0);
        driveIn(1, 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_row",       bus8.ascii_row,        ROW_SPACES);
        checkOutput("reset_ready",     128'(bus8.in_ready),   128'(1));
        checkOutput("reset_out_valid", 128'(bus8.out_valid),  128'(0));
        checkOutput("reset_overflow",  128'(bus8.overflow),   128'(0));
        checkOutput("reset_row10",     bus10.ascii_row,       ROW_SPACES);

        runSample8("s0",   16'd0,   "SENS: 000       ");
        runSample8("s255", 16'd255, "SENS: 255       ");
        runSample8("s123", 16'd123, "SENS: 123       ");

        applyStimulus(0, 16'd200, 3, 16'd50, 0, pulses, latency, row, ovf, rdyP, rr, rrdy);
        checkOutput("busy_row",     row,           "SENS: 200       ");
        checkOutput("busy_pulses",  128'(pulses),  128'(1));
        checkOutput("busy_latency", 128'(latency), 128'(10));

        applyStimulus(0, 16'd77, 0, 16'd0, 4, pulses, latency, row, ovf, rdyP, rr, rrdy);
        checkOutput("abort_pulses", 128'(pulses), 128'(0));
        checkOutput("abort_row",    rr,           ROW_SPACES);
        checkOutput("abort_ready",  128'(rrdy),   128'(1));
        checkOutput("abort_ovf",    128'(bus8.overflow), 128'(0));

        runSample8("s77", 16'd77, "SENS: 077       ");

        runSample10("d1000", 16'd1000, "SENS: 999       ", 1'b1);
        runSample10("d999",  16'd999,  "SENS: 999       ", 1'b0);

`ifdef LEADING_ZERO_BLANK_EN
        exp7  = "SENS:   7       ";
        exp0  = "SENS:   0       ";
        exp40 = "SENS:  40       ";
`else
        exp7  = "SENS: 007       ";
        exp0  = "SENS: 000       ";
        exp40 = "SENS: 040       ";
`endif
        runSample8("z7",  16'd7,  exp7);
        runSample8("z0",  16'd0,  exp0);
        runSample8("z40", 16'd40, exp40);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop in case a wait goes astray.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
